// File: rtl/mx12_seq_pkg.sv
// mx12_seq_pkg
//   Shared types and constants for the MX12 scalar-unit sequencer.
//   seq_state_t : sequencer phase encoding (3 bits)
//   VEC_*       : interrupt vector numbers presented on intr_vec
package mx12_seq_pkg;

   typedef enum logic [2:0] {
      RESET = 3'd0,
      FETCH = 3'd1,
      DEX   = 3'd2,
      DLS   = 3'd3,
      INTR  = 3'd4,
      HALT  = 3'd5
   } seq_state_t;

   localparam int VEC_NMI  = 0;
   localparam int VEC_BERR = 1;
   localparam int VEC_IRQ0 = 2;

endpackage

// File: rtl/mx12_irq_arb.sv
// mx12_irq_arb
//   NMI edge capture plus the maskable-IRQ priority encoder.
//   Ports:
//     clk, rst_n    : core clock, asynchronous active-low reset
//     nmi           : raw NMI line, rising-edge sensitive
//     nmi_serviced  : high during the INTR cycle that services vector 0
//     irq, irq_mask : level requests and per-line enables
//     gie           : global interrupt enable
//     nmi_pend      : an NMI edge is waiting to be serviced
//     irq_take      : at least one enabled IRQ is requesting and gie is set
//     irq_vec       : vector of the lowest-index enabled request (2+k)
//     irq_sel       : one-hot select of that same request
module mx12_irq_arb
   import mx12_seq_pkg::*;
#(
   parameter int IRQ_LINES = 4,
   parameter int VEC_W     = $clog2(IRQ_LINES + 2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 nmi,
   input  logic                 nmi_serviced,
   input  logic [IRQ_LINES-1:0] irq,
   input  logic [IRQ_LINES-1:0] irq_mask,
   input  logic                 gie,
   output logic                 nmi_pend,
   output logic                 irq_take,
   output logic [VEC_W-1:0]     irq_vec,
   output logic [IRQ_LINES-1:0] irq_sel
);

   logic                 nmi_q, nmi_d;
   logic                 nmi_pend_q, nmi_pend_d;
   logic [IRQ_LINES-1:0] req;

   // A fresh edge arriving in the very cycle an NMI is serviced wins over
   // the clear, so back-to-back NMIs are never lost.
   always_comb begin
      nmi_d      = nmi;
      nmi_pend_d = (nmi_pend_q & ~nmi_serviced) | (nmi & ~nmi_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nmi_q      <= 1'b0;
         nmi_pend_q <= 1'b0;
      end else begin
         nmi_q      <= nmi_d;
         nmi_pend_q <= nmi_pend_d;
      end
   end

   assign nmi_pend = nmi_pend_q;

   // Scan from the top down so the lowest set index is the last writer.
   always_comb begin
      req      = irq & irq_mask;
      irq_take = gie & (|req);
      irq_vec  = '0;
      irq_sel  = '0;
      for (int k = IRQ_LINES - 1; k >= 0; k--) begin
         if (req[k]) begin
            irq_sel    = '0;
            irq_sel[k] = 1'b1;
            irq_vec    = VEC_W'(VEC_IRQ0 + k);
         end
      end
   end

endmodule

// File: rtl/mx12_seq_ctrl.sv
// mx12_seq_ctrl
//   Core phase sequencer for the MX12 scalar unit: multi-byte fetch, decode,
//   load/store wait with watchdog, vectored interrupt entry and halt.
//   Ports:
//     clk, rst_n      : core clock, asynchronous active-low reset
//     ins_byte_valid  : fetch unit delivered one instruction byte
//     load/store/halt : decoder qualifiers, only looked at in DEX
//     ls_done         : LSU handshake completed
//     nmi             : non-maskable interrupt, rising-edge sensitive
//     irq, irq_mask   : level interrupt requests and their enables
//     gie             : global interrupt enable
//     fetch, dex, ls_active, intr, halted : one-hot phase strobes
//     ins_byte_idx    : byte currently being fetched
//     intr_vec        : vector latched on INTR entry (0 NMI, 1 bus err, 2+k IRQ k)
//     irq_ack         : one-hot acknowledge during an IRQ INTR cycle
//     bus_err         : watchdog timeout strobe on the final DLS cycle
module mx12_seq_ctrl
   import mx12_seq_pkg::*;
#(
   parameter int IRQ_LINES  = 4,
   parameter int INS_BYTES  = 2,
   parameter int LS_TIMEOUT = 255,
   parameter int VEC_W      = $clog2(IRQ_LINES + 2)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ins_byte_valid,
   input  logic                         load,
   input  logic                         store,
   input  logic                         halt,
   input  logic                         ls_done,
   input  logic                         nmi,
   input  logic [IRQ_LINES-1:0]         irq,
   input  logic [IRQ_LINES-1:0]         irq_mask,
   input  logic                         gie,
   output logic                         fetch,
   output logic [$clog2(INS_BYTES):0]   ins_byte_idx,
   output logic                         dex,
   output logic                         ls_active,
   output logic                         intr,
   output logic [VEC_W-1:0]             intr_vec,
   output logic [IRQ_LINES-1:0]         irq_ack,
   output logic                         bus_err,
   output logic                         halted
);

   localparam int CNT_W     = $clog2(INS_BYTES) + 1;
   localparam int WD_W      = (LS_TIMEOUT < 2) ? 1 : $clog2(LS_TIMEOUT);
   localparam int WD_LAST_I = (LS_TIMEOUT == 0) ? 0 : LS_TIMEOUT - 1;
   localparam logic             WD_EN    = (LS_TIMEOUT != 0);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_LAST_I);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INS_BYTES - 1);

   seq_state_t           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WD_W-1:0]      wd_q, wd_d;
   logic [VEC_W-1:0]     vec_q, vec_d;
   logic [IRQ_LINES-1:0] ack_q, ack_d;

   logic                 nmi_pend;
   logic                 irq_take;
   logic                 nmi_serviced;
   logic [VEC_W-1:0]     irq_vec;
   logic [IRQ_LINES-1:0] irq_sel;

   logic                 int_req;
   logic [VEC_W-1:0]     int_vec;
   logic [IRQ_LINES-1:0] int_ack;
   logic                 enter;
   logic [VEC_W-1:0]     enter_vec;
   logic [IRQ_LINES-1:0] enter_ack;
   logic                 timeout;

   mx12_irq_arb #(
      .IRQ_LINES (IRQ_LINES),
      .VEC_W     (VEC_W)
   ) u_irq_arb (
      .clk          (clk),
      .rst_n        (rst_n),
      .nmi          (nmi),
      .nmi_serviced (nmi_serviced),
      .irq          (irq),
      .irq_mask     (irq_mask),
      .gie          (gie),
      .nmi_pend     (nmi_pend),
      .irq_take     (irq_take),
      .irq_vec      (irq_vec),
      .irq_sel      (irq_sel)
   );

   // Only an NMI INTR cycle retires the pending NMI.
   assign nmi_serviced = (state_q == INTR) && (vec_q == VEC_W'(VEC_NMI));

   // Interrupt choice shared by every decision point that does not involve
   // the watchdog: NMI first, otherwise the winning maskable line.
   always_comb begin
      int_req = nmi_pend | irq_take;
      int_vec = irq_vec;
      int_ack = irq_sel;
      if (nmi_pend) begin
         int_vec = VEC_W'(VEC_NMI);
         int_ack = '0;
      end
      timeout = WD_EN && (wd_q == WD_LAST);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wd_d      = wd_q;
      vec_d     = vec_q;
      ack_d     = '0;
      bus_err   = 1'b0;
      enter     = 1'b0;
      enter_vec = int_vec;
      enter_ack = int_ack;

      unique case (state_q)
         RESET: state_d = FETCH;

         // Interrupts only at an instruction boundary, i.e. before byte 0.
         FETCH: begin
            if ((cnt_q == '0) && int_req) begin
               enter = 1'b1;
            end else if (ins_byte_valid) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = DEX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         // A pending NMI pre-empts the memory access; maskable IRQs do not.
         DEX: begin
            if (nmi_pend) begin
               enter = 1'b1;
            end else if (load | store) begin
               state_d = DLS;
               wd_d    = '0;
            end else if (irq_take) begin
               enter = 1'b1;
            end else if (halt) begin
               state_d = HALT;
            end else begin
               state_d = FETCH;
            end
         end

         // The access always runs to completion or timeout; ls_done beats
         // a simultaneous timeout.
         DLS: begin
            if (ls_done) begin
               if (int_req) begin
                  enter = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end else if (timeout) begin
               enter     = 1'b1;
               enter_vec = VEC_W'(VEC_BERR);
               enter_ack = '0;
               bus_err   = 1'b1;
            end else if (WD_EN) begin
               wd_d = wd_q + WD_W'(1);
            end
         end

         INTR: state_d = FETCH;

         HALT: begin
            if (int_req) begin
               enter = 1'b1;
            end
         end

         default: state_d = RESET;
      endcase

      if (enter) begin
         state_d = INTR;
         vec_d   = enter_vec;
         ack_d   = enter_ack;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET;
         cnt_q   <= '0;
         wd_q    <= '0;
         vec_q   <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wd_q    <= wd_d;
         vec_q   <= vec_d;
         ack_q   <= ack_d;
      end
   end

   assign fetch        = (state_q == FETCH);
   assign dex          = (state_q == DEX);
   assign ls_active    = (state_q == DLS);
   assign intr         = (state_q == INTR);
   assign halted       = (state_q == HALT);
   assign ins_byte_idx = cnt_q;
   assign intr_vec     = vec_q;
   assign irq_ack      = ack_q;

endmodule

// File: tb/tb_mx12_seq_ctrl.sv
// tb_mx12_seq_ctrl
//   Bench for mx12_seq_ctrl with IRQ_LINES=4, INS_BYTES=2, LS_TIMEOUT=8.
//   A vector table, hand-written multi-cycle sequences and a randomized run
//   are all compared against a behavioural model of the sequencer.
module tb_mx12_seq_ctrl;

   localparam int NB = 2;
   localparam int TO = 8;
   localparam int R = 0, F = 1, D = 2, L = 3, I = 4, H = 5;

   logic       clk = 1'b0;
   logic       rst_n, ins_byte_valid, load, store, halt, ls_done, nmi, gie;
   logic [3:0] irq, irq_mask;
   logic       fetch, dex, ls_active, intr, bus_err, halted;
   logic [1:0] ins_byte_idx;
   logic [2:0] intr_vec;
   logic [3:0] irq_ack;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   mx12_seq_ctrl #(
      .IRQ_LINES  (4),
      .INS_BYTES  (NB),
      .LS_TIMEOUT (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ins_byte_valid (ins_byte_valid),
      .load           (load),
      .store          (store),
      .halt           (halt),
      .ls_done        (ls_done),
      .nmi            (nmi),
      .irq            (irq),
      .irq_mask       (irq_mask),
      .gie            (gie),
      .fetch          (fetch),
      .ins_byte_idx   (ins_byte_idx),
      .dex            (dex),
      .ls_active      (ls_active),
      .intr           (intr),
      .intr_vec       (intr_vec),
      .irq_ack        (irq_ack),
      .bus_err        (bus_err),
      .halted         (halted)
   );

   typedef struct packed {
      logic       rst_n, v, ld, st, hl, dn, nmi;
      logic [3:0] irq, mask;
      logic       gie;
   } in_t;

   typedef struct {
      in_t in;
      int  ph, idx, vec, ack;
   } row_t;

   row_t tbl[$];

   // Behavioural model: phase, byte position, DLS cycle count, last vector,
   // NMI pending flag and previous NMI level.
   int m_ph, m_cnt, m_wd, m_vec;
   bit m_pend, m_prev;

   function automatic in_t sig(bit v = 0, bit ld = 0, bit st = 0, bit hl = 0,
                               bit dn = 0, bit nm = 0, logic [3:0] q = 4'h0,
                               logic [3:0] m = 4'h0, bit g = 0, bit r = 1);
      in_t x;
      x.rst_n = r;  x.v = v;   x.ld = ld; x.st = st; x.hl = hl;
      x.dn = dn;    x.nmi = nm; x.irq = q; x.mask = m; x.gie = g;
      return x;
   endfunction

   function automatic logic [14:0] exp_pack(int ph, int idx, int vec, int ack, bit be);
      logic [1:0] i2;
      logic [2:0] v3;
      logic [3:0] a4;
      i2 = idx[1:0];
      v3 = vec[2:0];
      a4 = ack[3:0];
      return {(ph == H), be, a4, v3, (ph == I), (ph == L), (ph == D), i2, (ph == F)};
   endfunction

   function automatic logic [14:0] out_pack();
      return {halted, bus_err, irq_ack, intr_vec, intr, ls_active, dex, ins_byte_idx, fetch};
   endfunction

   task automatic mreset();
      m_ph = R; m_cnt = 0; m_wd = 0; m_vec = 0; m_pend = 0; m_prev = 0;
   endtask

   function automatic int winner(in_t x);
      if (!x.gie) return -1;
      for (int k = 0; k < 4; k++)
         if (x.irq[k] && x.mask[k]) return k;
      return -1;
   endfunction

   function automatic logic [14:0] mexp(in_t x);
      int ack;
      bit be;
      ack = (m_ph == I && m_vec >= 2) ? (1 << (m_vec - 2)) : 0;
      be  = (m_ph == L) && (m_wd == TO - 1) && !x.dn;
      return exp_pack(m_ph, m_cnt, m_vec, ack, be);
   endfunction

   task automatic madv(in_t x);
      int  w, want, nxt;
      bit  serv;
      w    = winner(x);
      want = m_pend ? 0 : ((w >= 0) ? 2 + w : -1);
      nxt  = -1;
      serv = (m_ph == I) && (m_vec == 0);
      case (m_ph)
         R: m_ph = F;
         F: if (m_cnt == 0 && want >= 0) nxt = want;
            else if (x.v) begin
               if (m_cnt == NB - 1) begin m_ph = D; m_cnt = 0; end
               else m_cnt++;
            end
         D: if (m_pend) nxt = 0;
            else if (x.ld || x.st) begin m_ph = L; m_wd = 0; end
            else if (want >= 0) nxt = want;
            else if (x.hl) m_ph = H;
            else m_ph = F;
         L: if (x.dn) begin
               if (want >= 0) nxt = want; else m_ph = F;
            end else if (m_wd == TO - 1) nxt = 1;
            else m_wd++;
         I: m_ph = F;
         H: if (want >= 0) nxt = want;
         default: m_ph = R;
      endcase
      if (nxt >= 0) begin m_ph = I; m_vec = nxt; end
      m_pend = (m_pend && !serv) || (x.nmi && !m_prev);
      m_prev = x.nmi;
   endtask

   task automatic chk(string nm, logic [14:0] a, logic [14:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, a, e);
      end
   endtask

   // Entered at a falling edge: drive, settle, compare, advance the model,
   // and return at the next falling edge.
   task automatic cycle(in_t x, bit has, logic [14:0] e, string nm);
      rst_n = x.rst_n; ins_byte_valid = x.v; load = x.ld; store = x.st;
      halt = x.hl; ls_done = x.dn; nmi = x.nmi; irq = x.irq;
      irq_mask = x.mask; gie = x.gie;
      if (!x.rst_n) mreset();
      #1;
      chk({nm, "_model"}, out_pack(), mexp(x));
      if (has) chk(nm, out_pack(), e);
      if (x.rst_n) madv(x);
      cyc++;
      @(negedge clk);
   endtask

   task automatic st(in_t x, int ph, int idx, int vec, int ack, bit be, string nm);
      cycle(x, 1'b1, exp_pack(ph, idx, vec, ack, be), nm);
   endtask

   task automatic add(in_t x, int ph, int idx, int vec, int ack);
      row_t r;
      r.in = x; r.ph = ph; r.idx = idx; r.vec = vec; r.ack = ack;
      tbl.push_back(r);
   endtask

   initial begin
      rst_n = 1'b0; ins_byte_valid = 1'b0; load = 1'b0; store = 1'b0;
      halt = 1'b0; ls_done = 1'b0; nmi = 1'b0; irq = '0; irq_mask = '0; gie = 1'b0;
      mreset();
      @(negedge clk);

      // Reset, idle fetch, IRQ priority, gie gating, mid-instruction deferral
      add(sig(0,0,0,0,0,0,4'h0,4'h0,0,0), R, 0, 0, 0);
      add(sig(),                           R, 0, 0, 0);
      add(sig(1),                          F, 0, 0, 0);
      add(sig(1),                          F, 1, 0, 0);
      add(sig(),                           D, 0, 0, 0);
      add(sig(0,0,0,0,0,0,4'b1010,4'b1110,0), F, 0, 0, 0);
      add(sig(0,0,0,0,0,0,4'b1010,4'b1110,1), F, 0, 0, 0);
      add(sig(),                           I, 0, 3, 4'b0010);
      add(sig(),                           F, 0, 3, 0);
      add(sig(1),                          F, 0, 3, 0);
      add(sig(0,0,0,0,0,0,4'b0001,4'b0001,1), F, 1, 3, 0);
      add(sig(1,0,0,0,0,0,4'b0001,4'b0001,1), F, 1, 3, 0);
      add(sig(0,0,0,0,0,0,4'b0001,4'b0001,1), D, 0, 3, 0);
      add(sig(),                           I, 0, 2, 4'b0001);
      add(sig(),                           F, 0, 2, 0);
      foreach (tbl[n])
         st(tbl[n].in, tbl[n].ph, tbl[n].idx, tbl[n].vec, tbl[n].ack, 1'b0, "table");

      // NMI during DLS, then a second edge inside the NMI INTR cycle
      st(sig(1),            F, 0, 2, 0, 0, "nmi_f0");
      st(sig(1),            F, 1, 2, 0, 0, "nmi_f1");
      st(sig(0,0,1),        D, 0, 2, 0, 0, "nmi_dex");
      st(sig(0,0,0,0,0,1),  L, 0, 2, 0, 0, "nmi_dls_edge");
      st(sig(0,0,0,0,0,1),  L, 0, 2, 0, 0, "nmi_dls_hold1");
      st(sig(),             L, 0, 2, 0, 0, "nmi_dls_hold2");
      st(sig(0,0,0,0,1),    L, 0, 2, 0, 0, "nmi_dls_done");
      st(sig(0,0,0,0,0,1),  I, 0, 0, 0, 0, "nmi_intr1");
      st(sig(0,0,0,0,0,1),  F, 0, 0, 0, 0, "nmi_repend");
      st(sig(),             I, 0, 0, 0, 0, "nmi_intr2");
      st(sig(),             F, 0, 0, 0, 0, "nmi_cleared");
      st(sig(),             F, 0, 0, 0, 0, "nmi_idle");

      // Watchdog timeout: eight DLS cycles, bus_err on the last
      st(sig(1),            F, 0, 0, 0, 0, "wd_f0");
      st(sig(1),            F, 1, 0, 0, 0, "wd_f1");
      st(sig(0,0,1),        D, 0, 0, 0, 0, "wd_dex");
      for (int k = 0; k < TO - 1; k++) st(sig(), L, 0, 0, 0, 0, "wd_wait");
      st(sig(),             L, 0, 0, 0, 1, "wd_timeout");
      st(sig(),             I, 0, 1, 0, 0, "wd_intr");
      st(sig(),             F, 0, 1, 0, 0, "wd_after");

      // ls_done on the eighth cycle wins over the timeout
      st(sig(1),            F, 0, 1, 0, 0, "wdd_f0");
      st(sig(1),            F, 1, 1, 0, 0, "wdd_f1");
      st(sig(0,0,1),        D, 0, 1, 0, 0, "wdd_dex");
      for (int k = 0; k < TO - 1; k++) st(sig(), L, 0, 1, 0, 0, "wdd_wait");
      st(sig(0,0,0,0,1),    L, 0, 1, 0, 0, "wdd_done");
      st(sig(),             F, 0, 1, 0, 0, "wdd_fetch");

      // HALT: masked irq and decoder strobes ignored, NMI wakes
      st(sig(1),            F, 0, 1, 0, 0, "h_f0");
      st(sig(1),            F, 1, 1, 0, 0, "h_f1");
      st(sig(0,0,0,1),      D, 0, 1, 0, 0, "h_dex");
      for (int k = 0; k < 3; k++)
         st(sig(0,1,1,1,0,0,4'b0100,4'b1011,1), H, 0, 1, 0, 0, "h_masked");
      st(sig(0,0,0,0,0,1,4'b0100,4'b1011,1),    H, 0, 1, 0, 0, "h_edge");
      st(sig(0,0,0,0,0,1),  H, 0, 1, 0, 0, "h_pend");
      st(sig(),             I, 0, 0, 0, 0, "h_intr");
      st(sig(),             F, 0, 0, 0, 0, "h_fetch");

      // Asynchronous reset in the middle of DLS drops a pending NMI
      st(sig(1),            F, 0, 0, 0, 0, "r_f0");
      st(sig(1),            F, 1, 0, 0, 0, "r_f1");
      st(sig(0,1),          D, 0, 0, 0, 0, "r_dex");
      st(sig(),             L, 0, 0, 0, 0, "r_dls");
      st(sig(0,0,0,0,0,1),  L, 0, 0, 0, 0, "r_dls_nmi");
      st(sig(0,0,0,0,0,0,4'h0,4'h0,0,0), R, 0, 0, 0, 0, "r_async");
      st(sig(0,0,0,0,0,0,4'h0,4'h0,0,0), R, 0, 0, 0, 0, "r_held");
      st(sig(),             R, 0, 0, 0, 0, "r_release");
      st(sig(),             F, 0, 0, 0, 0, "r_no_nmi");
      st(sig(),             F, 0, 0, 0, 0, "r_idle");

      // Randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         in_t x;
         x.rst_n = ($urandom_range(0, 299) != 0);
         x.v     = 1'($urandom_range(0, 1));
         x.ld    = ($urandom_range(0, 5) == 0);
         x.st    = ($urandom_range(0, 5) == 0);
         x.hl    = ($urandom_range(0, 7) == 0);
         x.dn    = ($urandom_range(0, 11) == 0);
         x.nmi   = ($urandom_range(0, 9) == 0);
         x.irq   = 4'($urandom);
         x.mask  = 4'($urandom);
         x.gie   = ($urandom_range(0, 3) == 0);
         cycle(x, 1'b0, '0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
